// File: rtl/cpu_sequencer_pkg.sv
// Shared opcode, state and error encodings for the z0 sequencer and hub.
package cpu_sequencer_pkg;

  localparam logic [7:0] OP_MOVE = 8'h01;
  localparam logic [7:0] OP_LOAD = 8'h02;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM_RD = 3'd3,
    ST_COMMIT = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// Memory wait-cycle counter; expired_o flags the last allowed wait cycle without ready.
module cpu_sequencer_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // MEM_TIMEOUT == 0 disables expiry; the counter then just wraps harmlessly.
  assign expired_o = (MEM_TIMEOUT != 0) && en_i && !clear_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i || !en_i) begin
      count_d = '0;
    end else if (!expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// z0 fetch/decode/commit controller: owns PC/IR, drives the memory port and the commit strobe.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic [15:0] ld_addr,
  input  logic [15:0] hub_pc_next,
  output logic [15:0] ir,
  output logic [15:0] pc,
  output logic [15:0] load_data,
  output logic        is_loaded,
  output logic        reg_we,
  output logic        halted,
  output logic [1:0]  err
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] load_data_q, load_data_d;
  logic        is_loaded_q, is_loaded_d;
  err_e        err_q, err_d;
  logic        wait_en;
  logic        expired;

  assign wait_en = (state_q == ST_FETCH) || (state_q == ST_MEM_RD);

  cpu_sequencer_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .en_i     (wait_en),
    .clear_i  (mem_ready),
    .expired_o(expired)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    load_data_d = load_data_q;
    is_loaded_d = is_loaded_q;
    err_d       = err_q;
    mem_req     = 1'b0;
    mem_addr    = pc_q;
    reg_we      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = ST_DECODE;
        end else if (expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        case (ir_q[15:8])
          OP_MOVE: state_d = ST_COMMIT;
          OP_LOAD: state_d = ST_MEM_RD;
          OP_HALT: state_d = ST_HALT;
          default: begin
            err_d   = ERR_ILLEGAL;
            state_d = ST_HALT;
          end
        endcase
      end
      ST_MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = ld_addr;
        if (mem_ready) begin
          load_data_d = mem_rdata;
          is_loaded_d = 1'b1;
          state_d     = ST_COMMIT;
        end else if (expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_HALT;
        end
      end
      ST_COMMIT: begin
        reg_we      = 1'b1;
        pc_d        = hub_pc_next;
        is_loaded_d = 1'b0;
        state_d     = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      load_data_q <= '0;
      is_loaded_q <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      load_data_q <= load_data_d;
      is_loaded_q <= is_loaded_d;
      err_q       <= err_d;
    end
  end

  assign ir        = ir_q;
  assign pc        = pc_q;
  assign load_data = load_data_q;
  assign is_loaded = is_loaded_q;
  assign halted    = (state_q == ST_HALT);
  assign err       = err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized instruction-level bench for cpu_sequencer with a responder memory and expected-PC model.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n, run, mem_ready;
  logic [15:0] mem_rdata, ld_addr, hub_pc_next;
  logic        mem_req, is_loaded, reg_we, halted;
  logic [15:0] mem_addr, ir, pc, load_data;
  logic [1:0]  err;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [15:0] exp_pc;
  logic        rand_run = 1'b1;

  always #5 clk = ~clk;

  cpu_sequencer #(
    .RESET_PC   (RST_PC),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .ld_addr    (ld_addr),
    .hub_pc_next(hub_pc_next),
    .ir         (ir),
    .pc         (pc),
    .load_data  (load_data),
    .is_loaded  (is_loaded),
    .reg_we     (reg_we),
    .halted     (halted),
    .err        (err)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_pc",     pc,               RST_PC);
    check_eq("rst_ir",     ir,               16'h0000);
    check_eq("rst_ldata",  load_data,        16'h0000);
    check_eq("rst_req",    16'(mem_req),     16'd0);
    check_eq("rst_isld",   16'(is_loaded),   16'd0);
    check_eq("rst_we",     16'(reg_we),      16'd0);
    check_eq("rst_halted", 16'(halted),      16'd0);
    check_eq("rst_err",    16'(err),         16'd0);
    rst_n  = 1'b1;
    exp_pc = RST_PC;
  endtask

  task automatic idle_checks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_ready = 1'(($urandom & 1));
      check_eq("idle_req", 16'(mem_req), 16'd0);
      check_eq("idle_we",  16'(reg_we),  16'd0);
      check_eq("idle_pc",  pc,           exp_pc);
    end
    mem_ready = 1'b0;
  endtask

  task automatic start_run();
    run = 1'b1;
    @(negedge clk);
  endtask

  // Serves one memory read: w wait cycles then ready; returns at the next state's negedge.
  task automatic access(input string tag, input logic [15:0] addr, input int w, input logic [15:0] data);
    for (int i = 0; i <= w; i++) begin
      if (i > 0) @(negedge clk);
      check_eq({tag, "_req"},  16'(mem_req),   16'd1);
      check_eq({tag, "_addr"}, mem_addr,       addr);
      check_eq({tag, "_we"},   16'(reg_we),    16'd0);
      check_eq({tag, "_isld"}, 16'(is_loaded), 16'd0);
      mem_ready   = (i == w);
      mem_rdata   = (i == w) ? data : 16'($urandom);
      hub_pc_next = 16'($urandom);
      if (rand_run) run = 1'(($urandom & 1));
    end
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = 16'($urandom);
  endtask

  task automatic run_instr(input logic [15:0] instr, input int fw, input int lw, input logic [15:0] la,
                           input logic [15:0] ld, input logic [15:0] nxt, input logic keep);
    logic is_load;
    is_load = (instr[15:8] == OP_LOAD);
    ld_addr = 16'($urandom);
    access("fetch", exp_pc, fw, instr);
    check_eq("dec_req", 16'(mem_req), 16'd0);
    check_eq("dec_ir",  ir,           instr);
    check_eq("dec_we",  16'(reg_we),  16'd0);
    ld_addr = la;
    @(negedge clk);
    if (is_load) access("ldrd", la, lw, ld);
    check_eq("cmt_we",   16'(reg_we),    16'd1);
    check_eq("cmt_req",  16'(mem_req),   16'd0);
    check_eq("cmt_isld", 16'(is_loaded), 16'(is_load));
    if (is_load) check_eq("cmt_ldata", load_data, ld);
    check_eq("cmt_pc",   pc,             exp_pc);
    hub_pc_next = nxt;
    run         = keep;
    exp_pc      = nxt;
    @(negedge clk);
    hub_pc_next = 16'($urandom);
    check_eq("post_we",   16'(reg_we),    16'd0);
    check_eq("post_pc",   pc,             exp_pc);
    check_eq("post_isld", 16'(is_loaded), 16'd0);
    if (!keep) check_eq("post_req", 16'(mem_req), 16'd0);
  endtask

  task automatic halt_instr(input logic [15:0] instr, input int fw, input logic [1:0] exp_err);
    access("hfetch", exp_pc, fw, instr);
    check_eq("hdec_ir",     ir,           instr);
    check_eq("hdec_halted", 16'(halted),  16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'(($urandom & 1));
      run       = 1'(($urandom & 1));
      check_eq("halt_halted", 16'(halted),  16'd1);
      check_eq("halt_err",    16'(err),     16'(exp_err));
      check_eq("halt_req",    16'(mem_req), 16'd0);
      check_eq("halt_we",     16'(reg_we),  16'd0);
      check_eq("halt_pc",     pc,           exp_pc);
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    mem_rdata = '0; ld_addr = '0; hub_pc_next = '0;
    @(negedge clk);
    do_reset();
    idle_checks(2);

    // Zero-wait MOVE then a LOAD with three wait cycles on the data read.
    start_run();
    run_instr(16'h0100, 0, 0, 16'h0000, 16'h0000, 16'h0001, 1'b1);
    run_instr(16'h0200, 0, 3, 16'h0040, 16'hBEEF, 16'h0002, 1'b1);

    for (int k = 0; k < 150; k++) begin
      logic [15:0] instr;
      logic        keep;
      instr = {($urandom_range(0, 1) != 0) ? OP_LOAD : OP_MOVE, 8'($urandom)};
      keep  = ($urandom_range(0, 3) != 0);
      run_instr(instr, $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom),
                16'($urandom), 16'($urandom), keep);
      if (!keep) begin
        idle_checks($urandom_range(1, 3));
        start_run();
      end
    end

    // PC wrap with run dropped while fetching.
    run_instr(16'h0100, 1, 0, 16'h0000, 16'h0000, 16'hFFFF, 1'b1);
    rand_run = 1'b0;
    run      = 1'b0;
    run_instr(16'h0100, 2, 0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    rand_run = 1'b1;
    idle_checks(3);

    // Illegal opcode.
    start_run();
    halt_instr(16'h7700, 1, ERR_ILLEGAL);

    // OP_HALT after a MOVE.
    do_reset();
    start_run();
    run_instr(16'h0155, 0, 0, 16'h0000, 16'h0000, 16'h1234, 1'b1);
    halt_instr(16'hFF00, 2, ERR_NONE);

    // Fetch timeout: four wait cycles without ready.
    do_reset();
    start_run();
    for (int i = 0; i < 4; i++) begin
      check_eq("to_req",  16'(mem_req), 16'd1);
      check_eq("to_addr", mem_addr,     exp_pc);
      mem_ready = 1'b0;
      @(negedge clk);
    end
    check_eq("to_req_drop", 16'(mem_req), 16'd0);
    check_eq("to_halted",   16'(halted),  16'd1);
    check_eq("to_err",      16'(err),     16'(ERR_TIMEOUT));
    check_eq("to_pc",       pc,           exp_pc);

    // Reset during a LOAD data wait, followed by a late ready.
    do_reset();
    start_run();
    ld_addr = 16'h0040;
    access("r5fetch", exp_pc, 0, 16'h0200);
    @(negedge clk);
    check_eq("r5_req",  16'(mem_req), 16'd1);
    check_eq("r5_addr", mem_addr,     16'h0040);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("r5_req_low", 16'(mem_req), 16'd0);
    rst_n = 1'b1; run = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem_ready = 1'b0;
    check_eq("r5_pc",     pc,             RST_PC);
    check_eq("r5_isld",   16'(is_loaded), 16'd0);
    check_eq("r5_ldata",  load_data,      16'h0000);
    check_eq("r5_ir",     ir,             16'h0000);
    check_eq("r5_halted", 16'(halted),    16'd0);
    check_eq("r5_req2",   16'(mem_req),   16'd0);
    idle_checks(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
